output_port_ctrl: RTL
=====================

// Module: output_port_ctrl
// PURPOSE
//  Read side of the router input queues. One instance per router output port.
//  Round-robin arbitrates among NUM_IN input queues whose head packet targets this port.
//  Holds the grant and pops exactly PKT_FLITS flits (one packet) from the winner.
//  Drives the flits onto the output link, with backpressure from downstream.
// PARAMETERS
//  DATA_W     16  flit width, bits
//  NUM_IN     5   number of input queues (N,S,E,W,local)
//  PKT_FLITS  5   flits per packet (equals queue depth)
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous active-low reset
//  req_i       in   NUM_IN         bit i: queue i head packet targets this port
//  empty_i     in   NUM_IN         bit i: queue i empty (FIFO empty flag)
//  data_i      in   NUM_IN*DATA_W  queue i head flit at [i*DATA_W +: DATA_W], show-ahead
//  ready_i     in   1              downstream link can accept a flit this cycle
//  pop_o       out  NUM_IN         one-hot, active-high pop to the granted queue
//  grant_o     out  NUM_IN         one-hot registered grant; 0 when idle
//  data_o      out  DATA_W         registered output flit
//  valid_o     out  1              data_o valid this cycle
//  pkt_done_o  out  1              1-cycle pulse, registered, on the cycle after the last flit pops
// BEHAVIOUR
//  Reset (async assert, sync deassert by clk):
//   - state=IDLE; grant_o=0; data_o=0; valid_o=0; pkt_done_o=0; flit cnt=0.
//   - rr_ptr=NUM_IN-1, so queue 0 has first priority.
//   - Reset mid-packet aborts the packet; no further pops.
//  FSM states IDLE, SEND. The FSM is fully encoded; any unused state returns to IDLE.
//  IDLE:
//   - pop_o=0.
//   - If req_i!=0: winner = first set bit searching rr_ptr+1, rr_ptr+2, ... (mod NUM_IN).
//   - Then grant_o<=onehot(winner); rr_ptr<=winner; state<=SEND.
//   - Else stay in IDLE.
//  SEND (g = granted index):
//   - pop_o[g] = ready_i & ~empty_i[g], combinational; all other pop_o bits are 0.
//   - Pop cycle: data_o<=data_i[g]; valid_o<=1; cnt<=cnt+1.
//   - Non-pop cycle (stall): valid_o<=0; data_o holds its value; cnt holds.
//   - Pop with cnt==PKT_FLITS-1: cnt<=0; grant_o<=0; pkt_done_o<=1; state<=IDLE.
//   - req_i changes during SEND are ignored; the grant is locked for the whole packet.
//  Latency:
//   - Grant is visible 1 cycle after req_i is sampled in IDLE.
//   - Each flit appears on data_o/valid_o 1 cycle after its pop.
//   - Back-to-back packets leave exactly 1 idle cycle (IDLE) between them.
//  Width rules:
//   - cnt is $clog2(PKT_FLITS) bits and never exceeds PKT_FLITS-1.
//   - rr_ptr is $clog2(NUM_IN) bits; wrap is NUM_IN-1 -> 0, with no out-of-range value.
//  Boundary conditions:
//   - Granted queue goes empty mid-packet: stall until data is available; never pop when empty.
//   - ready_i low: no pop and no loss; the flit stays at the queue head.
//   - Single requester: it wins every packet.
//   - All requesting: grants rotate 0,1,2,3,4,0,...
//   - Invariants: pop_o and grant_o are each one-hot or 0; pop_o[i] is never 1 unless grant_o[i]=1.
// TESTING
//  T1: req_i=00001 after reset, data 0xA000..0xA004, ready=1 -> grant=00001 at cyc1.
//      pops cyc1-5; data_o A000..A004 with valid cyc2-6; pkt_done cyc6.
//  T2: req_i=11111 held, 3 packets -> grants 00001, 00010, 00100 in order.
//      Each packet is 5 flits; 1 idle cycle between packets.
//  T3: queue 2 granted, ready_i low on flits 2-3 for 3 cycles -> no pops while low.
//      data_o sequence intact, no duplicates; valid_o low for 3 cycles.
//  T4: granted queue empty_i=1 after 2 flits for 4 cycles -> pop_o=0, cnt holds.
//      Resumes, total 5 flits, pkt_done after the 5th.
//  T5: rst_n low after flit 3 -> all outputs 0 immediately.
//      After release, req_i=10000 wins via rr_ptr reset (queue 4 granted only if sole requester).
//  T6: req_i drops to 0 mid-packet -> packet still completes all 5 flits.

Source files
------------

// File: rtl/output_port_ctrl.sv
`default_nettype none
// ============================================================================
// output_port_ctrl
// Round-robin arbiter draining one whole packet at a time from the router
// input queues onto a single output link, with downstream backpressure.
// Rev 1.0
// ============================================================================
module output_port_ctrl #(
    parameter int DATA_W    = 16,
    parameter int NUM_IN    = 5,
    parameter int PKT_FLITS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        req_i,
    input  logic [NUM_IN-1:0]        empty_i,
    input  logic [NUM_IN*DATA_W-1:0] data_i,
    input  logic                     ready_i,
    output logic [NUM_IN-1:0]        pop_o,
    output logic [NUM_IN-1:0]        grant_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     pkt_done_o
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_FLITS - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_IN - 1);
    localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_IN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_IN-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                pkt_done_q, pkt_done_d;

    logic [DATA_W-1:0]   flit [NUM_IN];
    logic [PTR_W:0]      search_sum;
    logic [PTR_W-1:0]    search_idx;
    logic [PTR_W-1:0]    winner;
    logic                found;
    logic                pop_any;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign flit[i] = data_i[i*DATA_W +: DATA_W];
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found      = 1'b0;
        winner     = rr_ptr_q;
        search_sum = '0;
        search_idx = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            search_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (search_sum >= NUM_EXT) begin
                search_sum = search_sum - NUM_EXT;
            end
            search_idx = search_sum[PTR_W-1:0];
            if (!found && req_i[search_idx]) begin
                found  = 1'b1;
                winner = search_idx;
            end
        end
    end

    // The grant is one-hot, so masking it yields a pop only on the winner.
    assign pop_o   = (state_q == SEND) ? (grant_q & ~empty_i & {NUM_IN{ready_i}}) : '0;
    assign pop_any = |pop_o;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        pkt_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = NUM_IN'(1) << winner;
                    rr_ptr_d = winner;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (pop_any) begin
                    data_d  = flit[rr_ptr_q];
                    valid_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d      = '0;
                        grant_d    = '0;
                        pkt_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_RST;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign grant_o    = grant_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign pkt_done_o = pkt_done_q;

endmodule
`default_nettype wire
